demux_dispatch_ctrl: RTL and testbench

Sequencing controller for the 1x4 demultiplexer datapath. Accepts one word at a time from a single valid/ready source and steers it to one of four valid/ready sinks. Steering is either round-robin across enabled channels or explicitly addressed by a select input. Holds at most one word and sustains one word per cycle when sinks are ready.

---
 rtl/demux_dispatch_ctrl.sv | 112 +++++++++++
 tb/tb_demux_dispatch_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_dispatch_ctrl.sv
// One-word 1x4 demux sequencer: round-robin or addressed steering with valid/ready handshakes.
// Define DEMUX_SKIP_BUSY_EN to make round-robin prefer enabled sinks that are already ready.
module demux_dispatch_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [1:0]       in_sel,
    input  logic [3:0]       ch_en,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       last_ch,
    output logic             drop,
    output logic             busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [1:0]       tgt_q, tgt_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       lastCh_q, lastCh_d;
    logic [WIDTH-1:0] outData_q, outData_d;
    logic             drop_q, drop_d;

    logic             holding;
    logic             complete;
    logic             accept;
    logic             newValid;
    logic [1:0]       searchBase;
    logic [1:0]       rrTgt;
    logic [1:0]       newTgt;

    // First set bit of mask, scanning upward from base with wrap-around.
    function automatic logic [1:0] firstSet(input logic [3:0] mask, input logic [1:0] base);
        logic [1:0] idx;
        logic [1:0] cand;
        idx = base;
        for (int k = 3; k >= 0; k--) begin
            cand = base + 2'(k);
            if (mask[cand]) idx = cand;
        end
        return idx;
    endfunction

    assign holding    = (state_q == HOLD);
    assign complete   = holding && out_ready[tgt_q];
    assign in_ready   = (!holding || out_ready[tgt_q]) && (mode || (|ch_en));
    assign accept     = in_valid && in_ready;
    assign searchBase = complete ? (tgt_q + 2'd1) : ptr_q;

`ifdef DEMUX_SKIP_BUSY_EN
    assign rrTgt = (|(ch_en & out_ready)) ? firstSet(ch_en & out_ready, searchBase)
                                          : firstSet(ch_en, searchBase);
`else
    assign rrTgt = firstSet(ch_en, searchBase);
`endif

    assign newTgt   = mode ? in_sel : rrTgt;
    assign newValid = accept && (!mode || ch_en[in_sel]);

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        ptr_d     = ptr_q;
        lastCh_d  = lastCh_q;
        outData_d = outData_q;
        drop_d    = accept && mode && !ch_en[in_sel];
        if (complete) begin
            lastCh_d = tgt_q;
            ptr_d    = tgt_q + 2'd1;
        end
        if (newValid) begin
            state_d   = HOLD;
            tgt_d     = newTgt;
            outData_d = in_data;
        end else if (complete) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tgt_q     <= 2'd0;
            ptr_q     <= 2'd0;
            lastCh_q  <= 2'd0;
            outData_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            ptr_q     <= ptr_d;
            lastCh_q  <= lastCh_d;
            outData_q <= outData_d;
            drop_q    <= drop_d;
        end
    end

    assign out_data  = outData_q;
    assign out_valid = holding ? (4'b0001 << tgt_q) : 4'b0000;
    assign last_ch   = lastCh_q;
    assign drop      = drop_q;
    assign busy      = holding;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Bench for demux_dispatch_ctrl: behavioural dispatch model checked every cycle plus directed literal checks.
// Honours DEMUX_SKIP_BUSY_EN in both model and literal expectations.
module tb_demux_dispatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       mode = 1'b0;
    logic [1:0] in_sel = 2'd0;
    logic [3:0] ch_en = 4'h0;
    logic [7:0] out_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready = 4'h0;
    logic [1:0] last_ch;
    logic       drop;
    logic       busy;

    int compareCount = 0;
    int mismatchCount = 0;

    // Abstract model: is a word held, where it goes, and what the sinks have seen.
    int mBusy = 0;
    int mTgt = 0;
    int mPtr = 0;
    int mLast = 0;
    int mData = 0;
    int mDrop = 0;

    always #5 clk = ~clk;

    demux_dispatch_ctrl #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .in_sel   (in_sel),
        .ch_en    (ch_en),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .last_ch  (last_ch),
        .drop     (drop),
        .busy     (busy)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        compareCount++;
        if (actual != expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input int d, input bit m, input int sel,
                                 input int en, input int rdy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = 8'(d);
        mode      = m;
        in_sel    = 2'(sel);
        ch_en     = 4'(en);
        out_ready = 4'(rdy);
        #1;
    endtask

    function automatic int modelReady();
        return ((mBusy == 0 || out_ready[mTgt]) && (mode || ch_en != 4'h0)) ? 1 : 0;
    endfunction

    function automatic int rrPick(input int base);
`ifdef DEMUX_SKIP_BUSY_EN
        for (int k = 0; k < 4; k++)
            if (ch_en[(base + k) % 4] && out_ready[(base + k) % 4]) return (base + k) % 4;
`endif
        for (int k = 0; k < 4; k++)
            if (ch_en[(base + k) % 4]) return (base + k) % 4;
        return base;
    endfunction

    // Model step on each clock edge, asynchronous clear on reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy = 0; mTgt = 0; mPtr = 0; mLast = 0; mData = 0; mDrop = 0;
        end else begin
            int  rdyNow;
            bit  done;
            rdyNow = modelReady();
            done   = (mBusy != 0) && out_ready[mTgt];
            mDrop  = 0;
            if (done) begin
                mLast = mTgt;
                mPtr  = (mTgt + 1) % 4;
            end
            if (in_valid && rdyNow != 0) begin
                if (mode && !ch_en[in_sel]) begin
                    mDrop = 1;
                    if (done) mBusy = 0;
                end else begin
                    mTgt  = mode ? int'(in_sel) : rrPick(mPtr);
                    mData = int'(in_data);
                    mBusy = 1;
                end
            end else if (done) begin
                mBusy = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("cyc_out_valid", int'(out_valid), (mBusy != 0) ? (1 << mTgt) : 0);
            checkOutput("cyc_out_data", int'(out_data), mData);
            checkOutput("cyc_busy", int'(busy), mBusy);
            checkOutput("cyc_last_ch", int'(last_ch), mLast);
            checkOutput("cyc_drop", int'(drop), mDrop);
            checkOutput("cyc_in_ready", int'(in_ready), modelReady());
        end
    end

    initial begin
        $display("[TB] start");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_out_data", int'(out_data), 0);
        checkOutput("reset_last_ch", int'(last_ch), 0);
        checkOutput("reset_drop", int'(drop), 0);
        rst_n = 1'b1;

        // Round-robin over all four channels at full rate.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 8'h10 + i, 0, 0, 4'hF, 4'hF);
            checkOutput("rr_in_ready", int'(in_ready), 1);
            if (i > 0) begin
                checkOutput("rr_out_valid", int'(out_valid), 1 << ((i - 1) % 4));
                checkOutput("rr_out_data", int'(out_data), 8'h10 + i - 1);
            end
        end
        applyStimulus(0, 0, 0, 0, 4'hF, 4'hF);
        checkOutput("rr_last_valid", int'(out_valid), 4'b1000);
        checkOutput("rr_last_data", int'(out_data), 8'h17);

        // Sparse enable mask 1010.
        applyStimulus(1, 8'hA0, 0, 0, 4'b1010, 4'hF);
        checkOutput("sparse_idle", int'(busy), 0);
        applyStimulus(1, 8'hA1, 0, 0, 4'b1010, 4'hF);
        checkOutput("sparse_a0", int'(out_valid), 4'b0010);
        applyStimulus(1, 8'hA2, 0, 0, 4'b1010, 4'hF);
        checkOutput("sparse_a1", int'(out_valid), 4'b1000);
        applyStimulus(0, 0, 0, 0, 4'b1010, 4'hF);
        checkOutput("sparse_a2", int'(out_valid), 4'b0010);
        checkOutput("sparse_a2_data", int'(out_data), 8'hA2);

        // Addressed delivery, then a discard to a disabled channel.
        applyStimulus(1, 8'h55, 1, 2, 4'hF, 4'hF);
        applyStimulus(0, 0, 1, 2, 4'hF, 4'hF);
        checkOutput("addr_valid", int'(out_valid), 4'b0100);
        checkOutput("addr_data", int'(out_data), 8'h55);
        applyStimulus(1, 8'h66, 1, 3, 4'b0111, 4'hF);
        checkOutput("addr_last", int'(last_ch), 2);
        applyStimulus(0, 0, 1, 3, 4'b0111, 4'hF);
        checkOutput("drop_pulse", int'(drop), 1);
        checkOutput("drop_no_valid", int'(out_valid), 0);
        checkOutput("drop_last", int'(last_ch), 2);
        applyStimulus(0, 0, 1, 3, 4'b0111, 4'hF);
        checkOutput("drop_end", int'(drop), 0);

        // Backpressure on channel 0.
        applyStimulus(1, 8'h33, 1, 0, 4'hF, 4'b1110);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 8'h34, 1, 1, 4'hF, 4'b1110);
            checkOutput("bp_data", int'(out_data), 8'h33);
            checkOutput("bp_valid", int'(out_valid), 4'b0001);
            checkOutput("bp_in_ready", int'(in_ready), 0);
        end
        applyStimulus(1, 8'h34, 1, 1, 4'hF, 4'hF);
        checkOutput("bp_release_ready", int'(in_ready), 1);
        applyStimulus(0, 0, 1, 1, 4'hF, 4'hF);
        checkOutput("bp_last", int'(last_ch), 0);
        checkOutput("bp_next_valid", int'(out_valid), 4'b0010);
        checkOutput("bp_next_data", int'(out_data), 8'h34);

        // Move pointer to 0, then round-robin with only sink 2 ready.
        applyStimulus(1, 8'h3C, 1, 3, 4'hF, 4'hF);
        applyStimulus(0, 0, 1, 3, 4'hF, 4'hF);
        checkOutput("ptr_prep", int'(out_valid), 4'b1000);
        applyStimulus(1, 8'h77, 0, 0, 4'hF, 4'b0100);
        checkOutput("skip_idle", int'(busy), 0);
        applyStimulus(0, 0, 0, 0, 4'hF, 4'b0100);
`ifdef DEMUX_SKIP_BUSY_EN
        checkOutput("skip_target", int'(out_valid), 4'b0100);
`else
        checkOutput("skip_target", int'(out_valid), 4'b0001);
`endif
        applyStimulus(1, 8'h88, 0, 0, 4'hF, 4'b0000);
        applyStimulus(0, 0, 0, 0, 4'hF, 4'b0000);
        checkOutput("pre_reset_busy", int'(busy), 1);

        // Asynchronous reset while a word is held.
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", int'(out_valid), 0);
        checkOutput("async_rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1, 8'h99, 0, 0, 4'hF, 4'hF);
        applyStimulus(0, 0, 0, 0, 4'hF, 4'hF);
        checkOutput("post_rst_valid", int'(out_valid), 4'b0001);
        checkOutput("post_rst_data", int'(out_data), 8'h99);
        repeat (3) applyStimulus(0, 0, 0, 0, 4'hF, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
